keypad_encoder8to3: RTL

- Registered 8-to-3 priority encoder with debounce and a valid/ack handshake.
- Converts eight ATM menu/keypad lines (Btn[0]..Btn[7]) into a 3-bit selection code. The code maps to the same line index the team's 3-to-8 decoder uses: code 000 selects line 0, code 111 selects line 7.
- Sits between the front-panel inputs and the ATM control FSM. Each debounced key press produces exactly one code, delivered once and held until the control FSM acknowledges it.

---
 rtl/keypad_encoder8to3.sv | 134 +++++++++++++
 1 files changed

// File: rtl/keypad_encoder8to3.sv
// keypad_encoder8to3: registered 8-to-3 priority encoder for the ATM front panel.
// Debounces the eight key lines and reports each accepted press exactly once.
// Each code is held with Valid until the control FSM acknowledges it with Ack.
// Optional build macro MULTI_PRESS_REJECT_EN:
//   when defined, a press with more than one key down is rejected with a one-cycle
//   Err pulse instead of being priority-encoded.
module keypad_encoder8to3 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Btn,
  input  logic       Ack,
  output logic [2:0] Code,
  output logic       Valid,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  // Counter value on which the next matching sample completes the debounce.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       snapshot, snapshot_nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [2:0]       code_nxt;
  logic             valid_nxt;

  // Index of the highest set bit; Btn[7] has top priority.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef MULTI_PRESS_REJECT_EN
  logic err_q, err_nxt;

  // True when more than one key line is set.
  function automatic logic is_multi(input logic [7:0] v);
    return |(v & (v - 8'd1));
  endfunction

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  // Next-state and next-output logic for the press/handshake FSM.
  always_comb begin
    state_nxt    = state;
    snapshot_nxt = snapshot;
    counter_nxt  = counter;
    code_nxt     = Code;
    valid_nxt    = Valid;
`ifdef MULTI_PRESS_REJECT_EN
    err_nxt      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Btn != 8'd0) begin
          snapshot_nxt = Btn;
          counter_nxt  = '0;
          state_nxt    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (Btn != snapshot) begin
          // Any change, including release or a change on the completing edge, aborts.
          counter_nxt = '0;
          state_nxt   = IDLE;
        end else if (counter == DEB_LAST) begin
          counter_nxt = '0;
`ifdef MULTI_PRESS_REJECT_EN
          if (is_multi(snapshot)) begin
            err_nxt   = 1'b1;
            state_nxt = RELEASE;
          end else begin
            code_nxt  = encode(snapshot);
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
`else
          code_nxt  = encode(snapshot);
          valid_nxt = 1'b1;
          state_nxt = HOLD;
`endif
        end else begin
          counter_nxt = counter + 1'b1;
        end
      end
      HOLD: begin
        if (Ack) begin
          valid_nxt = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // A held key never produces a second code; wait for full release.
        if (Btn == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      snapshot <= 8'd0;
      counter  <= '0;
      Code     <= 3'd0;
      Valid    <= 1'b0;
`ifdef MULTI_PRESS_REJECT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      snapshot <= snapshot_nxt;
      counter  <= counter_nxt;
      Code     <= code_nxt;
      Valid    <= valid_nxt;
`ifdef MULTI_PRESS_REJECT_EN
      err_q    <= err_nxt;
`endif
    end
  end

endmodule
